// File: rtl/zktc_gpio.sv
// zktc_gpio: memory-mapped GPIO bank for the ZKTC core's word-addressed peripheral bus.
// Provides per-pin direction, output data, synchronised input sampling and
// per-pin edge interrupts (rising or falling), with a level irq output.
// Register map (word address):
//   0 DOUT  RW     1 DIR   RW     2 DIN   RO     3 IEN  RW
//   4 EDGE  RW     5 ISTAT R/W1C  6 TOGL  WO     7 reserved
// Register bits above N_PINS read as zero and ignore writes.
module zktc_gpio #(
    parameter int N_PINS      = 8,
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_we,
    input  logic              bus_re,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_rvalid,
    input  logic [N_PINS-1:0] pin_in,
    output logic [N_PINS-1:0] pin_out,
    output logic [N_PINS-1:0] pin_oe,
    output logic              irq
);

    // ------------------------------------------------------------------
    // Register addresses
    // ------------------------------------------------------------------
    localparam logic [ADDR_W-1:0] ADDR_DOUT  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_DIR   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_DIN   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_IEN   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] ADDR_EDGE  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ADDR_ISTAT = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] ADDR_TOGL  = ADDR_W'(6);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [N_PINS-1:0] dout_reg;
    logic [N_PINS-1:0] dout_next;
    logic [N_PINS-1:0] dir_reg;
    logic [N_PINS-1:0] ien_reg;
    logic [N_PINS-1:0] edge_reg;
    logic [N_PINS-1:0] istat_reg;
    logic [N_PINS-1:0] istat_next;
    logic [N_PINS-1:0] sync_reg [SYNC_STAGES];
    logic [N_PINS-1:0] prev_reg;
    logic              irq_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [DATA_W-1:0] rdata_next;
    logic              rvalid_reg;

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    logic [N_PINS-1:0] wdata_pins;
    logic              wr_dout;
    logic              wr_dir;
    logic              wr_ien;
    logic              wr_edge;
    logic              wr_istat;
    logic              wr_togl;
    logic [N_PINS-1:0] istat_clr;

    // Bits of the write bus above N_PINS are deliberately discarded.
    logic unused_wdata;
    assign unused_wdata = ^bus_wdata;

    assign wdata_pins = bus_wdata[N_PINS-1:0];
    assign wr_dout    = bus_we && (bus_addr == ADDR_DOUT);
    assign wr_dir     = bus_we && (bus_addr == ADDR_DIR);
    assign wr_ien     = bus_we && (bus_addr == ADDR_IEN);
    assign wr_edge    = bus_we && (bus_addr == ADDR_EDGE);
    assign wr_istat   = bus_we && (bus_addr == ADDR_ISTAT);
    assign wr_togl    = bus_we && (bus_addr == ADDR_TOGL);
    assign istat_clr  = wr_istat ? wdata_pins : '0;

    // ------------------------------------------------------------------
    // Input path: synchroniser and edge detection
    // ------------------------------------------------------------------
    logic [N_PINS-1:0] din;
    logic [N_PINS-1:0] rise;
    logic [N_PINS-1:0] fall;
    logic [N_PINS-1:0] edge_hit;

    assign din = sync_reg[SYNC_STAGES-1];

    // Shift the asynchronous pad value through the synchroniser chain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_reg[s] <= '0;
            end
        end else begin
            sync_reg[0] <= pin_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_reg[s] <= sync_reg[s-1];
            end
        end
    end

    // Keep a one-cycle-old copy of DIN for edge comparison.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_reg <= '0;
        end else begin
            prev_reg <= din;
        end
    end

    // Per-pin edge select and ISTAT update; a new edge beats a same-cycle W1C.
    generate
        for (genvar gi = 0; gi < N_PINS; gi++) begin : g_pin
            assign rise[gi]       = din[gi] & ~prev_reg[gi];
            assign fall[gi]       = ~din[gi] & prev_reg[gi];
            assign edge_hit[gi]   = edge_reg[gi] ? fall[gi] : rise[gi];
            assign istat_next[gi] = edge_hit[gi] | (istat_reg[gi] & ~istat_clr[gi]);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output data: direct write or write-1-to-toggle
    // ------------------------------------------------------------------
    // Select the next DOUT value from a plain write or a toggle write.
    always_comb begin
        dout_next = dout_reg;
        if (wr_dout) begin
            dout_next = wdata_pins;
        end else if (wr_togl) begin
            dout_next = dout_reg ^ wdata_pins;
        end
    end

    // Control registers commit on the edge carrying the write strobe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_reg  <= '0;
            dir_reg   <= '0;
            ien_reg   <= '0;
            edge_reg  <= '0;
            istat_reg <= '0;
        end else begin
            dout_reg  <= dout_next;
            istat_reg <= istat_next;
            if (wr_dir) begin
                dir_reg <= wdata_pins;
            end
            if (wr_ien) begin
                ien_reg <= wdata_pins;
            end
            if (wr_edge) begin
                edge_reg <= wdata_pins;
            end
        end
    end

    // Level interrupt, registered from the current pending/enable state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= |(istat_reg & ien_reg);
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    // Read mux sees pre-write register values, so read-during-write returns old data.
    always_comb begin
        rdata_next = '0;
        case (bus_addr)
            ADDR_DOUT:  rdata_next[N_PINS-1:0] = dout_reg;
            ADDR_DIR:   rdata_next[N_PINS-1:0] = dir_reg;
            ADDR_DIN:   rdata_next[N_PINS-1:0] = din;
            ADDR_IEN:   rdata_next[N_PINS-1:0] = ien_reg;
            ADDR_EDGE:  rdata_next[N_PINS-1:0] = edge_reg;
            ADDR_ISTAT: rdata_next[N_PINS-1:0] = istat_reg;
            default:    rdata_next = '0;
        endcase
    end

    // Capture read data on a read strobe and hold it until the next read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
        end else begin
            rvalid_reg <= bus_re;
            if (bus_re) begin
                rdata_reg <= rdata_next;
            end
        end
    end

    assign bus_rdata  = rdata_reg;
    assign bus_rvalid = rvalid_reg;
    assign pin_out    = dout_reg;
    assign pin_oe     = dir_reg;
    assign irq        = irq_reg;

endmodule
